// File: rtl/vscale_htif_pcr_arbiter.sv
// vscale_htif_pcr_arbiter: round-robin share of the HTIF PCR port between the tohost poller and the fromhost writer
module vscale_htif_pcr_arbiter #(
    parameter int HTIF_PCR_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  req_valid_i,
    output logic [1:0]                  req_ready_o,
    input  logic [1:0]                  req_rw_i,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [2*HTIF_PCR_WIDTH-1:0] req_data_i,
    output logic [1:0]                  resp_valid_o,
    input  logic [1:0]                  resp_ready_i,
    output logic [HTIF_PCR_WIDTH-1:0]   resp_data_o,
    output logic                        resp_err_o,
    output logic                        htif_pcr_req_valid,
    input  logic                        htif_pcr_req_ready,
    output logic                        htif_pcr_req_rw,
    output logic [ADDR_WIDTH-1:0]       htif_pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0]   htif_pcr_req_data,
    input  logic                        htif_pcr_resp_valid,
    output logic                        htif_pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0]   htif_pcr_resp_data,
    output logic                        busy_o,
    output logic                        owner_o,
    output logic                        stray_resp_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_t;
    state_t state, next_state;
    logic prio, win, accept, expired;
    logic [CW-1:0] cnt;
    logic [HTIF_PCR_WIDTH-1:0] rdata_q;
    logic err_q;
    assign win = &req_valid_i ? prio : req_valid_i[1];
    assign accept = state == IDLE && |req_valid_i;
    assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= next_state;
    always_comb
        next_state = state == IDLE ? (accept ? REQ : IDLE) :
                     state == REQ  ? (htif_pcr_req_ready ? RESP : REQ) :
                     state == RESP ? ((htif_pcr_resp_valid || expired) ? DELIVER : RESP) :
                                     (resp_ready_i[owner_o] ? IDLE : DELIVER);
    always_comb begin
        req_ready_o = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
        resp_valid_o = state == DELIVER ? (owner_o ? 2'b10 : 2'b01) : 2'b00;
        htif_pcr_req_valid = state == REQ;
        htif_pcr_resp_ready = state == IDLE || state == RESP;
        busy_o = state != IDLE;
        resp_data_o = rdata_q;
        resp_err_o = err_q;
    end
    // A real response in the expiry cycle takes precedence over the forced error.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
            owner_o <= 1'b0;
            htif_pcr_req_rw <= 1'b0;
            htif_pcr_req_addr <= '0;
            htif_pcr_req_data <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
            cnt <= '0;
            stray_resp_o <= 1'b0;
        end else begin
            if (accept) begin
                owner_o <= win;
                htif_pcr_req_rw <= req_rw_i[win];
                htif_pcr_req_addr <= win ? req_addr_i[ADDR_WIDTH +: ADDR_WIDTH] : req_addr_i[0 +: ADDR_WIDTH];
                htif_pcr_req_data <= win ? req_data_i[HTIF_PCR_WIDTH +: HTIF_PCR_WIDTH] : req_data_i[0 +: HTIF_PCR_WIDTH];
            end
            if (state == REQ && htif_pcr_req_ready) cnt <= '0;
            if (state == RESP) begin
                if (htif_pcr_resp_valid) begin
                    rdata_q <= htif_pcr_resp_data;
                    err_q <= 1'b0;
                end else if (expired) begin
                    rdata_q <= '1;
                    err_q <= 1'b1;
                end else cnt <= &cnt ? cnt : cnt + 1'b1;
            end
            if (state == DELIVER && resp_ready_i[owner_o]) prio <= ~owner_o;
            if (state == IDLE && htif_pcr_resp_valid) stray_resp_o <= 1'b1;
        end
    end
endmodule
